// File: rtl/fetcher_pkg.sv
// Shared stage and state codes for the instruction fetcher and the core
// sequencer that drives it.
package fetcher_pkg;

    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    localparam int TIMER_BITS = 8;
    localparam int COUNT_BITS = 16;

endpackage

// File: rtl/fetcher.sv
// Instruction fetcher: issues one program-memory read per CORE_FETCH stage,
// holds the returned word for decode, and gives up after a bounded wait.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_timeout,
    output logic [COUNT_BITS-1:0]            fetch_count
);

    // Handshake: mem_read_valid rises with the address latched and stays high
    // with that address stable until the first cycle mem_read_ready is high
    // (data sampled in that same cycle) or the wait budget runs out.

    localparam logic [TIMER_BITS-1:0] TIMEOUT_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    fetcher_state_t        state;
    fetcher_state_t        state_next;
    logic [TIMER_BITS-1:0] wait_timer;
    logic                  timer_expired;

    assign timer_expired = (wait_timer == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCHER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    state_next = FETCHER_FETCHING;
                end
            end
            FETCHER_FETCHING: begin
                if (mem_read_ready || timer_expired) begin
                    state_next = FETCHER_FETCHED;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_next = FETCHER_IDLE;
                end
            end
            default: state_next = FETCHER_IDLE;
        endcase
    end

    always_comb begin
        mem_read_valid = (state == FETCHER_FETCHING);
        fetcher_state  = state;
    end

    // Ready takes priority over expiry so a word arriving on the last allowed
    // cycle is still delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_address <= '0;
            instruction      <= '0;
            fetch_timeout    <= 1'b0;
            fetch_count      <= '0;
            wait_timer       <= '0;
        end else begin
            unique case (state)
                FETCHER_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        mem_read_address <= current_pc;
                        wait_timer       <= '0;
                    end
                end
                FETCHER_FETCHING: begin
                    if (mem_read_ready) begin
                        instruction <= mem_read_data;
                        if (fetch_count != {COUNT_BITS{1'b1}}) begin
                            fetch_count <= fetch_count + 1'b1;
                        end
                    end else if (timer_expired) begin
                        fetch_timeout <= 1'b1;
                        instruction   <= '0;
                    end else begin
                        wait_timer <= wait_timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Directed scenarios for the fetcher with a scoreboard of expected
// instruction words checked as each fetch lands in FETCHED.
module tb_fetcher;
    import fetcher_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  core_state = CORE_IDLE;
    logic [7:0]  current_pc = 8'h00;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = 16'h0000;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_timeout;
    logic [15:0] fetch_count;

    logic [15:0] exp_q[$];
    logic [15:0] exp_count = 16'h0000;
    logic        exp_timeout = 1'b0;
    logic [15:0] exp_instr;
    int n_cmp = 0;
    int n_bad = 0;

    fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .fetch_timeout(fetch_timeout),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_q.delete();
        exp_count = 16'h0000;
        exp_timeout = 1'b0;
    endtask

    task automatic start_fetch(input logic [7:0] pc);
        core_state = CORE_FETCH;
        current_pc = pc;
        cycle();
        core_state = CORE_WAIT;
        n_cmp++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== pc || fetcher_state !== 3'b001) begin
            n_bad++;
            $display("FAIL start_fetch: valid=%b addr=%h state=%b, want valid=1 addr=%h state=001",
                     mem_read_valid, mem_read_address, fetcher_state, pc);
        end
    endtask

    task automatic respond(input int waits, input logic [15:0] data, input logic [7:0] addr_exp);
        for (int i = 0; i < waits; i++) begin
            n_cmp++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== addr_exp) begin
                n_bad++;
                $display("FAIL wait_hold: valid=%b addr=%h, want valid=1 addr=%h",
                         mem_read_valid, mem_read_address, addr_exp);
            end
            cycle();
        end
        mem_read_ready = 1'b1;
        mem_read_data = data;
        exp_q.push_back(data);
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'h0001;
        cycle();
        mem_read_ready = 1'b0;
        mem_read_data = 16'($urandom);
        exp_instr = exp_q.pop_front();
        n_cmp++;
        if (fetcher_state !== 3'b010 || mem_read_valid !== 1'b0 || instruction !== exp_instr
            || fetch_count !== exp_count || fetch_timeout !== exp_timeout) begin
            n_bad++;
            $display("FAIL fetched: state=%b valid=%b instr=%h count=%0d to=%b, want 010 0 %h %0d %b",
                     fetcher_state, mem_read_valid, instruction, fetch_count, fetch_timeout,
                     exp_instr, exp_count, exp_timeout);
        end
    endtask

    task automatic finish_decode();
        core_state = CORE_DECODE;
        cycle();
        core_state = CORE_IDLE;
        n_cmp++;
        if (fetcher_state !== 3'b000 || mem_read_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL decode_idle: state=%b valid=%b, want 000 0", fetcher_state, mem_read_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (fetcher_state !== 3'b000 || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00
            || instruction !== 16'h0000 || fetch_timeout !== 1'b0 || fetch_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset: state=%b valid=%b addr=%h instr=%h to=%b count=%0d, want all zero",
                     fetcher_state, mem_read_valid, mem_read_address, instruction, fetch_timeout, fetch_count);
        end
    endtask

    task automatic test_normal_fetch();
        start_fetch(8'h05);
        respond(2, 16'h1234, 8'h05);
        finish_decode();
    endtask

    task automatic test_same_cycle_ready();
        start_fetch(8'h20);
        respond(0, 16'h5A5A, 8'h20);
        finish_decode();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] pc;
            pc = 8'($urandom_range(0, 255));
            start_fetch(pc);
            respond($urandom_range(0, 2), 16'($urandom), pc);
            finish_decode();
        end
    endtask

    task automatic test_pc_change();
        start_fetch(8'h05);
        current_pc = 8'h09;
        respond(2, 16'h0F0F, 8'h05);
        // stray ready and a fresh FETCH request while still FETCHED
        core_state = CORE_FETCH;
        mem_read_ready = 1'b1;
        mem_read_data = 16'hFFFF;
        cycle();
        cycle();
        mem_read_ready = 1'b0;
        n_cmp++;
        if (instruction !== 16'h0F0F || fetcher_state !== 3'b010 || mem_read_valid !== 1'b0
            || fetch_count !== exp_count || mem_read_address !== 8'h05) begin
            n_bad++;
            $display("FAIL fetched_ignore: instr=%h state=%b valid=%b count=%0d addr=%h, want 0f0f 010 0 %0d 05",
                     instruction, fetcher_state, mem_read_valid, fetch_count, mem_read_address, exp_count);
        end
        finish_decode();
        mem_read_ready = 1'b1;
        mem_read_data = 16'hEEEE;
        cycle();
        mem_read_ready = 1'b0;
        n_cmp++;
        if (instruction !== 16'h0F0F || fetcher_state !== 3'b000 || fetch_count !== exp_count) begin
            n_bad++;
            $display("FAIL idle_ignore: instr=%h state=%b count=%0d, want 0f0f 000 %0d",
                     instruction, fetcher_state, fetch_count, exp_count);
        end
    endtask

    task automatic test_tie();
        start_fetch(8'h33);
        respond(3, 16'hABCD, 8'h33);
        finish_decode();
    endtask

    task automatic test_reset_mid_fetch();
        start_fetch(8'h44);
        cycle();
        reset = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data = 16'h5555;
        cycle();
        reset = 1'b0;
        mem_read_ready = 1'b0;
        exp_q.delete();
        exp_count = 16'h0000;
        exp_timeout = 1'b0;
        n_cmp++;
        if (fetcher_state !== 3'b000 || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00
            || instruction !== 16'h0000 || fetch_timeout !== 1'b0 || fetch_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid: state=%b valid=%b addr=%h instr=%h to=%b count=%0d, want all zero",
                     fetcher_state, mem_read_valid, mem_read_address, instruction, fetch_timeout, fetch_count);
        end
        start_fetch(8'h07);
        respond(1, 16'h7777, 8'h07);
        finish_decode();
    endtask

    task automatic test_timeout();
        start_fetch(8'h66);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_read_valid !== 1'b1 || fetch_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait%0d: valid=%b to=%b, want 1 0", i, mem_read_valid, fetch_timeout);
            end
            cycle();
        end
        exp_timeout = 1'b1;
        exp_q.push_back(16'h0000);
        exp_instr = exp_q.pop_front();
        n_cmp++;
        if (mem_read_valid !== 1'b0 || fetch_timeout !== 1'b1 || instruction !== exp_instr
            || fetch_count !== exp_count || fetcher_state !== 3'b010) begin
            n_bad++;
            $display("FAIL timeout: valid=%b to=%b instr=%h count=%0d state=%b, want 0 1 %h %0d 010",
                     mem_read_valid, fetch_timeout, instruction, fetch_count, fetcher_state,
                     exp_instr, exp_count);
        end
        finish_decode();
        start_fetch(8'h67);
        respond(0, 16'hC0DE, 8'h67);
        finish_decode();
        n_cmp++;
        if (fetch_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: to=%b, want 1", fetch_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_normal_fetch();
        test_same_cycle_ready();
        test_back_to_back();
        test_pc_change();
        test_tie();
        test_reset_mid_fetch();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
